// File: rtl/bk_kbd_pkg.sv
// Shared constants for the BK-0010 PS/2 keyboard front end: set-2 scancodes,
// BK (KOI-7) codes and the prefix FSM state type.
package bk_kbd_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_AA     = 8'hAA;
  localparam logic [7:0] SC_FA     = 8'hFA;
  localparam logic [7:0] SC_EE     = 8'hEE;
  localparam logic [7:0] SC_FE     = 8'hFE;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_F12    = 8'h07;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;

  localparam logic [6:0] BK_ENTER  = 7'o012;
  localparam logic [6:0] BK_BKSP   = 7'o030;
  localparam logic [6:0] BK_TAB    = 7'o015;
  localparam logic [6:0] BK_ESC    = 7'o003;
  localparam logic [6:0] BK_SPACE  = 7'o040;
  localparam logic [6:0] BK_RUS    = 7'o016;
  localparam logic [6:0] BK_LAT    = 7'o017;
  localparam logic [6:0] BK_UP     = 7'o032;
  localparam logic [6:0] BK_DOWN   = 7'o031;
  localparam logic [6:0] BK_LEFT   = 7'o010;
  localparam logic [6:0] BK_RIGHT  = 7'o033;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK
  } prefix_state_t;

  // Keyboard self-test/ack/resend bytes and the Pause prefix carry no key info.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_E1) || (b == SC_AA) || (b == SC_FA) ||
           (b == SC_EE) || (b == SC_FE);
  endfunction

endpackage

// File: rtl/bk_kbd_xlat.sv
// Combinational set-2 scancode to 7-bit KOI-7 translation; returns 0 for keys
// that have no BK code. Ctrl masking is done by the caller.
module bk_kbd_xlat
  import bk_kbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       rus,
  output logic [6:0] code
);

  logic [4:0] letter;

  always_comb begin
    letter = 5'd0;
    case (scancode)
      8'h1C: letter = 5'd1;   8'h32: letter = 5'd2;   8'h21: letter = 5'd3;
      8'h23: letter = 5'd4;   8'h24: letter = 5'd5;   8'h2B: letter = 5'd6;
      8'h34: letter = 5'd7;   8'h33: letter = 5'd8;   8'h43: letter = 5'd9;
      8'h3B: letter = 5'd10;  8'h42: letter = 5'd11;  8'h4B: letter = 5'd12;
      8'h3A: letter = 5'd13;  8'h31: letter = 5'd14;  8'h44: letter = 5'd15;
      8'h4D: letter = 5'd16;  8'h15: letter = 5'd17;  8'h2D: letter = 5'd18;
      8'h1B: letter = 5'd19;  8'h2C: letter = 5'd20;  8'h3C: letter = 5'd21;
      8'h2A: letter = 5'd22;  8'h1D: letter = 5'd23;  8'h22: letter = 5'd24;
      8'h35: letter = 5'd25;  8'h1A: letter = 5'd26;
      default: letter = 5'd0;
    endcase
  end

  // Letters sit at 0100+n; bit 040 selects the other case/alphabet.
  always_comb begin
    code = 7'd0;
    if (ext) begin
      case (scancode)
        SC_UP:    code = BK_UP;
        SC_DOWN:  code = BK_DOWN;
        SC_LEFT:  code = BK_LEFT;
        SC_RIGHT: code = BK_RIGHT;
        default:  code = 7'd0;
      endcase
    end else if (letter != 5'd0) begin
      code = {1'b1, rus ^ shift, letter};
    end else begin
      case (scancode)
        SC_ENTER: code = BK_ENTER;
        SC_BKSP:  code = BK_BKSP;
        SC_TAB:   code = BK_TAB;
        SC_ESC:   code = BK_ESC;
        SC_SPACE: code = BK_SPACE;
        default:  code = 7'd0;
      endcase
    end
  end

endmodule

// File: rtl/bk_kbd_ctrl.sv
// PS/2 keyboard front end for the BK-0010: receiver, prefix FSM, modifiers and
// code holding. Define BK_KBD_FIFO_EN to queue codes in a FIFO_DEPTH FIFO.
module bk_kbd_ctrl
  import bk_kbd_pkg::*;
#(
  parameter int TIMEOUT_W  = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       ce,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       read_kbd,
  output logic [7:0] kbd_data,
  output logic       kbd_available,
  output logic       kbd_ar2,
  output logic       stopkey,
  output logic       keydown,
  output logic       frame_err
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  logic [1:0]           clk_sync, dat_sync;
  logic                 clk_prev;
  logic [3:0]           bit_cnt;
  logic [7:0]           shreg, rx_byte;
  logic                 par_bit, rx_valid;
  logic [TIMEOUT_W-1:0] tcnt;
  logic                 clk_fall, clk_edge, dat_bit;

  assign clk_fall = clk_prev & ~clk_sync[1];
  assign clk_edge = clk_prev ^ clk_sync[1];
  assign dat_bit  = dat_sync[1];

  // Frame: start, 8 data LSB first, odd parity, stop; bit_cnt counts received bits.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      clk_prev  <= 1'b1;
      bit_cnt   <= 4'd0;
      shreg     <= 8'd0;
      par_bit   <= 1'b0;
      rx_byte   <= 8'd0;
      rx_valid  <= 1'b0;
      tcnt      <= '0;
      frame_err <= 1'b0;
    end else if (ce) begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      dat_sync  <= {dat_sync[0], ps2_dat};
      clk_prev  <= clk_sync[1];
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (clk_edge)
        tcnt <= '0;
      else if (bit_cnt != 4'd0)
        tcnt <= tcnt + TIMEOUT_W'(1);
      if (clk_fall) begin
        if (bit_cnt == 4'd0) begin
          if (!dat_bit) bit_cnt <= 4'd1;
          else          frame_err <= 1'b1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {dat_bit, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par_bit <= dat_bit;
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (dat_bit && ((^shreg) ^ par_bit)) begin
            rx_byte  <= shreg;
            rx_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if ((bit_cnt != 4'd0) && (&tcnt)) begin
        bit_cnt   <= 4'd0;
        frame_err <= 1'b1;
      end
    end
  end

  prefix_state_t state, state_nxt;
  logic          is_make, is_brk, ext;
  logic          shift_f, ctrl_f, alt_f, rus;
  logic [3:0]    held_cnt;
  logic [6:0]    xlat_code, enq_code;
  logic          enq;
  logic          is_shift, is_ctrl, is_alt, is_mod, is_caps, is_f12;

  bk_kbd_xlat u_xlat (
    .ext      (ext),
    .scancode (rx_byte),
    .shift    (shift_f),
    .rus      (rus),
    .code     (xlat_code)
  );

  assign is_shift = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);
  assign is_ctrl  = (rx_byte == SC_CTRL);
  assign is_alt   = (rx_byte == SC_ALT);
  assign is_mod   = is_shift | is_ctrl | is_alt;
  assign is_caps  = !ext && (rx_byte == SC_CAPS);
  assign is_f12   = !ext && (rx_byte == SC_F12);

  always_comb begin
    state_nxt = state;
    is_make   = 1'b0;
    is_brk    = 1'b0;
    ext       = 1'b0;
    enq       = 1'b0;
    enq_code  = 7'd0;
    if (rx_valid && !is_ignored(rx_byte)) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == SC_E0)      state_nxt = ST_EXT;
          else if (rx_byte == SC_F0) state_nxt = ST_BRK;
          else                       is_make   = 1'b1;
        end
        ST_EXT: begin
          ext = 1'b1;
          if (rx_byte == SC_F0) begin
            state_nxt = ST_EXTBRK;
          end else begin
            is_make   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_brk    = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXTBRK: begin
          is_brk    = 1'b1;
          ext       = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    if (is_make) begin
      if (is_caps) begin
        enq      = 1'b1;
        enq_code = rus ? BK_LAT : BK_RUS;
      end else if (xlat_code != 7'd0) begin
        enq      = 1'b1;
        enq_code = ctrl_f ? (xlat_code & 7'o037) : xlat_code;
      end
    end
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state    <= ST_IDLE;
      shift_f  <= 1'b0;
      ctrl_f   <= 1'b0;
      alt_f    <= 1'b0;
      rus      <= 1'b0;
      held_cnt <= 4'd0;
      stopkey  <= 1'b0;
    end else if (ce) begin
      state <= state_nxt;
      if (is_make) begin
        if (is_shift) shift_f <= 1'b1;
        if (is_ctrl)  ctrl_f  <= 1'b1;
        if (is_alt)   alt_f   <= 1'b1;
        if (!is_mod && (held_cnt != 4'd15)) held_cnt <= held_cnt + 4'd1;
        if (is_caps)  rus     <= ~rus;
        if (is_f12)   stopkey <= 1'b1;
      end
      if (is_brk) begin
        if (is_shift) shift_f <= 1'b0;
        if (is_ctrl)  ctrl_f  <= 1'b0;
        if (is_alt)   alt_f   <= 1'b0;
        if (!is_mod && (held_cnt != 4'd0)) held_cnt <= held_cnt - 4'd1;
        if (is_f12)   stopkey <= 1'b0;
      end
    end
  end

  assign keydown = (held_cnt != 4'd0);

  logic read_prev, ack;
  assign ack = read_prev & ~read_kbd;

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset)  read_prev <= 1'b0;
    else if (ce)  read_prev <= read_kbd;
  end

`ifdef BK_KBD_FIFO_EN
  localparam int         AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign pop  = ack && (count != '0);
  assign push = enq && ((count != FULL) || pop);

  // Each entry is {alt, code}; a push while full is allowed only alongside a pop.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (ce) begin
      if (push) begin
        mem[wr_ptr] <= {alt_f, enq_code};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign kbd_available = (count != '0);
  assign kbd_data      = {1'b0, mem[rd_ptr][6:0]};
  assign kbd_ar2       = kbd_available & mem[rd_ptr][7];
`else
  logic [6:0] data_q;
  logic       avail_q, ar2_q;

  // A new code beats a same-cycle acknowledge; otherwise codes arriving while full are lost.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      data_q  <= 7'd0;
      avail_q <= 1'b0;
      ar2_q   <= 1'b0;
    end else if (ce) begin
      if (enq && (!avail_q || ack)) begin
        data_q  <= enq_code;
        ar2_q   <= alt_f;
        avail_q <= 1'b1;
      end else if (ack) begin
        avail_q <= 1'b0;
        ar2_q   <= 1'b0;
      end
    end
  end

  assign kbd_available = avail_q;
  assign kbd_data      = {1'b0, data_q};
  assign kbd_ar2       = ar2_q;
`endif

endmodule

// File: tb/tb_bk_kbd_ctrl.sv
// Self-checking bench for bk_kbd_ctrl: directed scenarios plus random key
// events, checked against a behavioural keyboard model (honours BK_KBD_FIFO_EN).
module tb_bk_kbd_ctrl;

  logic       m_clock = 1'b0;
  logic       p_reset, ce, ps2_clk, ps2_dat, read_kbd;
  logic [7:0] kbd_data;
  logic       kbd_available, kbd_ar2, stopkey, keydown, frame_err;

  always #5 m_clock = ~m_clock;

  bk_kbd_ctrl #(.TIMEOUT_W(8), .FIFO_DEPTH(4)) dut (
    .m_clock       (m_clock),
    .p_reset       (p_reset),
    .ce            (ce),
    .ps2_clk       (ps2_clk),
    .ps2_dat       (ps2_dat),
    .read_kbd      (read_kbd),
    .kbd_data      (kbd_data),
    .kbd_available (kbd_available),
    .kbd_ar2       (kbd_ar2),
    .stopkey       (stopkey),
    .keydown       (keydown),
    .frame_err     (frame_err)
  );

  int errors = 0;
  int checks = 0;
  int feCount = 0;
  int feExpected = 0;

  always @(posedge m_clock) if (frame_err === 1'b1) feCount++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of what a BK should see for a given byte stream.
  bit mExt, mBrk, mShift, mCtrl, mAlt, mRus, mStop;
  int mHeld;
  int q[$];
  int mData;
  bit mAvail, mAr2;
  logic [7:0] letterSc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  function automatic int xlatModel(bit e, logic [7:0] b, bit sh, bit ru);
    if (e) begin
      case (b)
        8'h75: return 26;
        8'h72: return 25;
        8'h6B: return 8;
        8'h74: return 27;
        default: return 0;
      endcase
    end
    for (int i = 0; i < 26; i++)
      if (letterSc[i] == b) return 65 + i + ((sh != ru) ? 32 : 0);
    case (b)
      8'h5A: return 10;
      8'h66: return 24;
      8'h0D: return 13;
      8'h76: return 3;
      8'h29: return 32;
      default: return 0;
    endcase
  endfunction

  function automatic void modelEnq(int code);
`ifdef BK_KBD_FIFO_EN
    if (q.size() < 4) q.push_back((mAlt ? 128 : 0) + code);
`else
    if (!mAvail) begin
      mData  = code;
      mAr2   = mAlt;
      mAvail = 1'b1;
    end
`endif
  endfunction

  function automatic void modelMake(bit e, logic [7:0] b);
    int c;
    if (b == 8'h12 || b == 8'h59) mShift = 1'b1;
    else if (b == 8'h14) mCtrl = 1'b1;
    else if (b == 8'h11) mAlt = 1'b1;
    else begin
      if (mHeld < 15) mHeld++;
      if (!e && b == 8'h58) begin
        mRus = !mRus;
        modelEnq(mRus ? 14 : 15);
      end else if (!e && b == 8'h07) begin
        mStop = 1'b1;
      end else begin
        c = xlatModel(e, b, mShift, mRus);
        if (c != 0) modelEnq(mCtrl ? c % 32 : c);
      end
    end
  endfunction

  function automatic void modelBreak(bit e, logic [7:0] b);
    if (b == 8'h12 || b == 8'h59) mShift = 1'b0;
    else if (b == 8'h14) mCtrl = 1'b0;
    else if (b == 8'h11) mAlt = 1'b0;
    else begin
      if (mHeld > 0) mHeld--;
      if (!e && b == 8'h07) mStop = 1'b0;
    end
  endfunction

  function automatic void modelByte(logic [7:0] b);
    if (b == 8'hE1 || b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) return;
    if (mBrk) begin
      modelBreak(mExt, b);
      mBrk = 1'b0;
      mExt = 1'b0;
    end else if (b == 8'hE0 && !mExt) begin
      mExt = 1'b1;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      modelMake(mExt, b);
      mExt = 1'b0;
    end
  endfunction

  function automatic void modelAck();
`ifdef BK_KBD_FIFO_EN
    if (q.size() != 0) void'(q.pop_front());
`else
    mAvail = 1'b0;
    mAr2   = 1'b0;
`endif
  endfunction

  task automatic compareAll(input string tag);
`ifdef BK_KBD_FIFO_EN
    checkOutput({tag, "_avail"}, 32'(kbd_available), 32'(q.size() != 0));
    if (q.size() != 0) begin
      checkOutput({tag, "_data"}, 32'(kbd_data), 32'(q[0] % 128));
      checkOutput({tag, "_ar2"}, 32'(kbd_ar2), 32'(q[0] / 128));
    end else begin
      checkOutput({tag, "_ar2"}, 32'(kbd_ar2), 32'd0);
    end
`else
    checkOutput({tag, "_avail"}, 32'(kbd_available), 32'(mAvail));
    checkOutput({tag, "_data"}, 32'(kbd_data), 32'(mData));
    checkOutput({tag, "_ar2"}, 32'(kbd_ar2), 32'(mAr2));
`endif
    checkOutput({tag, "_keydown"}, 32'(keydown), 32'(mHeld != 0));
    checkOutput({tag, "_stopkey"}, 32'(stopkey), 32'(mStop));
  endtask

  // PS/2 device side: data changes while the clock is high, sampled on its fall.
  task automatic sendFrame(input logic [7:0] b, input bit badPar);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_dat = bits[i];
      repeat (4) @(negedge m_clock);
      ps2_clk = 1'b0;
      repeat (8) @(negedge m_clock);
      ps2_clk = 1'b1;
      repeat (4) @(negedge m_clock);
    end
    ps2_dat = 1'b1;
    repeat (12) @(negedge m_clock);
  endtask

  task automatic sendPartial(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = (i == 0) ? 1'b0 : 1'b1;
      repeat (4) @(negedge m_clock);
      ps2_clk = 1'b0;
      repeat (8) @(negedge m_clock);
      ps2_clk = 1'b1;
      repeat (4) @(negedge m_clock);
    end
    ps2_dat = 1'b1;
    repeat (300) @(negedge m_clock);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    sendFrame(b, 1'b0);
    modelByte(b);
  endtask

  task automatic keyEvent(input bit e, input logic [7:0] b, input bit brk, input string tag);
    if (e) applyStimulus(8'hE0);
    if (brk) applyStimulus(8'hF0);
    applyStimulus(b);
    compareAll(tag);
  endtask

  task automatic doAck();
    read_kbd = 1'b1;
    repeat (3) @(negedge m_clock);
    read_kbd = 1'b0;
    repeat (4) @(negedge m_clock);
    modelAck();
  endtask

  logic [7:0] poolSc  [16] = '{8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58,
                               8'h07, 8'h5A, 8'h66, 8'h29, 8'h75, 8'h6B, 8'h0D, 8'h4E};
  bit         poolExt [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fe0, k;
    p_reset = 1'b1; ce = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; read_kbd = 1'b0;
    repeat (5) @(negedge m_clock);
    checkOutput("rst_avail", 32'(kbd_available), 32'd0);
    checkOutput("rst_data", 32'(kbd_data), 32'd0);
    p_reset = 1'b0;
    repeat (5) @(negedge m_clock);
    checkOutput("rst_ar2", 32'(kbd_ar2), 32'd0);
    checkOutput("rst_stopkey", 32'(stopkey), 32'd0);
    checkOutput("rst_keydown", 32'(keydown), 32'd0);
    checkOutput("rst_frame_err", 32'(feCount), 32'd0);

    keyEvent(0, 8'h1C, 0, "a_make");
    checkOutput("a_code", 32'(kbd_data), 32'o101);
    checkOutput("a_keydown", 32'(keydown), 32'd1);
    keyEvent(0, 8'h1C, 1, "a_break");
    checkOutput("a_keyup", 32'(keydown), 32'd0);
    doAck();
    checkOutput("a_ack", 32'(kbd_available), 32'd0);
    compareAll("a_ack");

    keyEvent(0, 8'h58, 0, "caps_on");
    checkOutput("caps_rus_code", 32'(kbd_data), 32'o016);
    doAck();
    keyEvent(0, 8'h58, 1, "caps_rel");
    keyEvent(0, 8'h1C, 0, "rus_a");
    checkOutput("rus_a_code", 32'(kbd_data), 32'o141);
    keyEvent(0, 8'h1C, 1, "rus_a_rel");
    doAck();
    keyEvent(0, 8'h12, 0, "shift_make");
    keyEvent(0, 8'h1C, 0, "rus_shift_a");
    checkOutput("rus_shift_a_code", 32'(kbd_data), 32'o101);
    keyEvent(0, 8'h1C, 1, "rus_shift_a_rel");
    keyEvent(0, 8'h12, 1, "shift_break");
    doAck();
    keyEvent(0, 8'h58, 0, "caps_off");
    checkOutput("caps_lat_code", 32'(kbd_data), 32'o017);
    keyEvent(0, 8'h58, 1, "caps_off_rel");
    doAck();

    keyEvent(0, 8'h11, 0, "alt_make");
    keyEvent(0, 8'h1C, 0, "alt_a");
    checkOutput("alt_a_code", 32'(kbd_data), 32'o101);
    checkOutput("alt_a_ar2", 32'(kbd_ar2), 32'd1);
    doAck();
    checkOutput("alt_ack_ar2", 32'(kbd_ar2), 32'd0);
    keyEvent(0, 8'h1C, 1, "alt_a_rel");
    keyEvent(0, 8'h11, 1, "alt_break");

    keyEvent(0, 8'h07, 0, "f12_make");
    checkOutput("f12_stop_on", 32'(stopkey), 32'd1);
    checkOutput("f12_no_code", 32'(kbd_available), 32'd0);
    keyEvent(0, 8'h07, 1, "f12_break");
    checkOutput("f12_stop_off", 32'(stopkey), 32'd0);
    keyEvent(1, 8'h75, 0, "up_make");
    checkOutput("up_code", 32'(kbd_data), 32'o032);
    doAck();
    keyEvent(1, 8'h75, 1, "up_break");

    fe0 = feCount;
    sendFrame(8'h1C, 1'b1);
    feExpected++;
    checkOutput("parity_err_pulse", 32'(feCount - fe0), 32'd1);
    compareAll("parity_err");
    fe0 = feCount;
    sendPartial(4);
    feExpected++;
    checkOutput("timeout_err_pulse", 32'(feCount - fe0), 32'd1);
    keyEvent(0, 8'h1C, 0, "after_timeout");
    checkOutput("after_timeout_code", 32'(kbd_data), 32'o101);
    keyEvent(0, 8'h1C, 1, "after_timeout_rel");
    doAck();

    keyEvent(0, 8'h1C, 0, "five_1"); keyEvent(0, 8'h1C, 1, "five_1r");
    keyEvent(0, 8'h32, 0, "five_2"); keyEvent(0, 8'h32, 1, "five_2r");
    keyEvent(0, 8'h21, 0, "five_3"); keyEvent(0, 8'h21, 1, "five_3r");
    keyEvent(0, 8'h23, 0, "five_4"); keyEvent(0, 8'h23, 1, "five_4r");
    keyEvent(0, 8'h24, 0, "five_5"); keyEvent(0, 8'h24, 1, "five_5r");
`ifdef BK_KBD_FIFO_EN
    for (int i = 0; i < 4; i++) begin
      checkOutput("five_readout", 32'(kbd_data), 32'(65 + i));
      doAck();
    end
`else
    checkOutput("five_held_first", 32'(kbd_data), 32'o101);
    doAck();
`endif
    checkOutput("five_drained", 32'(kbd_available), 32'd0);
    compareAll("five_end");

    for (int n = 0; n < 45; n++) begin
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 4) == 0) doAck();
      if ($urandom_range(0, 9) == 0) begin
        applyStimulus(8'hFA);
        compareAll("rnd_ignored");
      end
      keyEvent(poolExt[k], poolSc[k], $urandom_range(0, 1) == 1, "rnd");
    end

    checkOutput("frame_err_total", 32'(feCount), 32'(feExpected));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bk_kbd_ctrl.md
# bk_kbd_ctrl

PS/2 keyboard front end for the BK-0010 core: deserialises the PS/2 line, tracks set-2 make/break/extended prefixes and modifier state, and translates key presses into 7-bit BK (KOI-7) codes. It sits directly upstream of `bkcore`. It drives `kbd_data`, `kbd_available`, `kbd_ar2`, `stopkey` and `keydown`, and consumes `read_kbd` to acknowledge a code.

## Interface
- `TIMEOUT_W`, default 14: width of the inter-bit timeout counter, in `ce` ticks. Terminal count aborts a partial frame.
- `FIFO_DEPTH`, default 4: pending-code depth. Power of two. Used only with `KBD_FIFO_EN`.

Ports:
- `m_clock` in 1: system clock.
- `p_reset` in 1: asynchronous, active-high reset.
- `ce` in 1: clock enable. All state advances only when `ce`=1.
- `ps2_clk` in 1: raw PS/2 clock line, asynchronous.
- `ps2_dat` in 1: raw PS/2 data line, asynchronous.
- `read_kbd` in 1: high while the CPU addresses 177662.
- `kbd_data` out 8: current code `{1'b0, code[6:0]}`.
- `kbd_available` out 1: a code is pending.
- `kbd_ar2` out 1: the pending code was typed with Alt (AR2).
- `stopkey` out 1: level, high while F12 (STOP) is held.
- `keydown` out 1: level, high while any non-modifier key is held.
- `frame_err` out 1: one-`ce` pulse on a parity, start or stop error, or on a timeout.

## Operation
- **Receiver.** `ps2_clk`/`ps2_dat` pass through 2-flop synchronisers. Bits are sampled on a detected falling edge of the synchronised clock. The frame is start(0), 8 data bits LSB first, odd parity, stop(1). A bad start, parity or stop bit pulses `frame_err` and discards the byte. Timeout counter: cleared on each edge, counts `ce` ticks while the bit count is nonzero, and at all-ones resets the bit count and pulses `frame_err`.
- **Prefix FSM.** States IDLE, EXT (after E0), BRK (after F0), EXTBRK (after E0 F0).
  - IDLE: E0 goes to EXT, F0 goes to BRK. Any other byte is a make code and returns to IDLE.
  - EXT: F0 goes to EXTBRK. Any other byte is an extended make.
  - BRK and EXTBRK: the next byte is a break and the FSM returns to IDLE.
  - E1 and bytes AA/FA/EE/FE are ignored in all states and do not change state.
- **Modifiers.** Registered flags `shift` (12/59), `ctrl` (14, E0 14), `alt` (11, E0 11) set on make and clear on break. CapsLock (58) make toggles `rus`, reset value 0 (LAT), and enqueues 016 when entering RUS and 017 when entering LAT.
- **Keydown.** Tracked with a held-key counter, 4 bits, saturating at 15 and floored at 0. Non-modifier make increments, break decrements. `keydown` = (count != 0).
- **Stopkey.** F12 (07) make sets `stopkey`, break clears it. F12 never enqueues a code.
- **Translation.** `{ext, scancode, shift, rus}` maps to a 7-bit code; 0 means unmapped, and unmapped keys are dropped.
  - Letters: LAT gives 0101–0132. RUS sets bit 040. Shift inverts bit 040.
  - `ctrl` applied: result = code & 037.
  - Fixed keys: Enter 5A gives 012, Backspace 66 gives 030, Tab 0D gives 015, Esc 76 gives 003, arrows E0 75/72/6B/74 give 032/031/010/033, Space 29 gives 040.
- **Enqueue, without `KBD_FIFO_EN`.** If `kbd_available`=0: load `kbd_data`, latch `kbd_ar2` = `alt`, set `kbd_available`. If `kbd_available`=1 the new code is dropped.
- **Acknowledge.** On a falling edge of `read_kbd` (sampled on `ce`), clear `kbd_available` and `kbd_ar2`. `kbd_data` holds its value. If an acknowledge and an enqueue happen in the same cycle, the enqueue wins: the new code loads and `kbd_available` stays 1.

## Timing
- **Reset.** All outputs 0; FSM in IDLE; modifiers, `rus` and the counter 0; FIFO empty. Reset mid-frame discards the partial byte.
- **Latency.** The stop-bit sample occurs on `ce` tick N. The byte is valid at N+1. `kbd_available` and `kbd_data` (or `stopkey`) update at N+2.
- **Prefix timing.** Prefix bytes change only FSM state and produce no output.
- **Read visibility.** `kbd_data` is stable while `kbd_available`=1, so `bkcore`'s combinational read sees a steady value.

## Configuration
- `BK_KBD_FIFO_EN` defined: codes, each with its `alt` bit, go into a `FIFO_DEPTH` FIFO. The head drives `kbd_data`/`kbd_ar2`, `kbd_available` = !empty, and acknowledge pops. An enqueue when full is dropped. Simultaneous push and pop while full is allowed and keeps the count. Pointers wrap modulo `FIFO_DEPTH`.
- `BK_KBD_FIFO_EN` undefined: single holding register as described in Operation.

## Structure
- Package `bk_kbd_pkg`:
  - scancode constants: E0, F0, and the modifier, F12, CapsLock and fixed-key codes;
  - BK code constants: 012, 030, 016, 017, the arrow codes;
  - the prefix FSM state enum.
- Sub-module `bk_kbd_xlat`: purely combinational scancode-to-KOI-7 table. Inputs `ext`, `scancode`, `shift`, `rus`; output a 7-bit code. Ctrl masking is applied in the parent.

## Test plan
- Frame 1C (A), then F0 1C, LAT mode → `kbd_data`=0101, `kbd_available`=1 at N+2. `keydown` goes 1 then 0. A `read_kbd` fall clears `kbd_available`.
- Make 58 (CapsLock), acknowledge, then 1C → codes 016, then 0141. With shift (12) held, 1C → 0101.
- 11 (Alt) make, then 1C → `kbd_data`=0101 and `kbd_ar2`=1. The acknowledge clears `kbd_ar2`.
- 07 make, then F0 07 → `stopkey` high only between the two, with no `kbd_available` pulse. E0 75 → 032.
- Frame with wrong parity → `frame_err` pulse and no output change. Frame aborted after 4 bits → timeout `frame_err`, and the next good frame decodes.
- Five keys with no acknowledge: with `BK_KBD_FIFO_EN`, four are held, read out in order, and the fifth is dropped; without it, only the first is held.
